alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command issuer for an external combinational ALU: accepts one command, drives the ALU
// for one cycle, captures result and flags, and holds them until the response is taken.
// Optional feature macro ALU_CMD_ISSUER_CHAIN_EN adds cmd_chain (reuse last result as operand a).
module alu_cmd_issuer #(
    parameter int OPW  = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OPW-1:0]  cmd_a,
    input  logic [OPW-1:0]  cmd_b,
    input  logic [2:0]      cmd_op,
`ifdef ALU_CMD_ISSUER_CHAIN_EN
    input  logic            cmd_chain,
`endif
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [OPW-1:0]  alu_res,
    input  logic            alu_car,
    input  logic            alu_of,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [OPW-1:0]  rsp_res,
    output logic            rsp_car,
    output logic            rsp_of,
    output logic            rsp_zero,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [OPW-1:0]  opa_q,       opa_d;
    logic [OPW-1:0]  opb_q,       opb_d;
    logic [2:0]      opc_q,       opc_d;
    logic [OPW-1:0]  rsp_res_q,   rsp_res_d;
    logic            rsp_car_q,   rsp_car_d;
    logic            rsp_of_q,    rsp_of_d;
    logic            rsp_zero_q,  rsp_zero_d;
    logic [CNTW-1:0] op_count_q,  op_count_d;
    logic            chain_s;

`ifdef ALU_CMD_ISSUER_CHAIN_EN
    assign chain_s = cmd_chain;
`else
    assign chain_s = 1'b0;
`endif

    // Next-state and next-output computation; alu_* inputs are only sampled in DRIVE.
    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        opc_d      = opc_q;
        rsp_res_d  = rsp_res_q;
        rsp_car_d  = rsp_car_q;
        rsp_of_d   = rsp_of_q;
        rsp_zero_d = rsp_zero_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = DRIVE;
                    // rsp_res_q still holds the last completed result while in IDLE
                    opa_d   = chain_s ? rsp_res_q : cmd_a;
                    opb_d   = cmd_b;
                    opc_d   = cmd_op;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                state_d    = RESP;
                rsp_res_d  = alu_res;
                rsp_car_d  = alu_car;
                rsp_of_d   = alu_of;
                rsp_zero_d = (alu_res == {OPW{1'b0}});
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and registered outputs; rst overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            opa_q       <= {OPW{1'b0}};
            opb_q       <= {OPW{1'b0}};
            opc_q       <= 3'b000;
            rsp_res_q   <= {OPW{1'b0}};
            rsp_car_q   <= 1'b0;
            rsp_of_q    <= 1'b0;
            rsp_zero_q  <= 1'b0;
            op_count_q  <= {CNTW{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
            rsp_res_q   <= rsp_res_d;
            rsp_car_q   <= rsp_car_d;
            rsp_of_q    <= rsp_of_d;
            rsp_zero_q  <= rsp_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign alu_ctrl  = opc_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_car   = rsp_car_q;
    assign rsp_of    = rsp_of_q;
    assign rsp_zero  = rsp_zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized self-checking bench for alu_cmd_issuer with an arithmetic ALU reference model.
module tb_alu_cmd_issuer;

    localparam int OPW  = 4;
    localparam int CNTW = 8;
    localparam int FULL = 1 << OPW;
    localparam int HALF = FULL / 2;
`ifdef ALU_CMD_ISSUER_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [OPW-1:0]  cmd_a, cmd_b;
    logic [2:0]      cmd_op;
`ifdef ALU_CMD_ISSUER_CHAIN_EN
    logic            cmd_chain;
`endif
    logic [OPW-1:0]  alu_a, alu_b, alu_res;
    logic [2:0]      alu_ctrl;
    logic            alu_car, alu_of;
    logic            rsp_valid, rsp_ready;
    logic [OPW-1:0]  rsp_res;
    logic            rsp_car, rsp_of, rsp_zero;
    logic [CNTW-1:0] op_count;
    logic [OPW+1:0]  alu_noise;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    int cyc     = 0;
    logic [OPW-1:0] last_res;

    alu_cmd_issuer #(.OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
`ifdef ALU_CMD_ISSUER_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_of(rsp_of), .rsp_zero(rsp_zero),
        .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU in plain integer arithmetic; returns {car, of, res}.
    function automatic logic [OPW+1:0] alu_model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                                 input logic [2:0] op);
        int ua, ub, sa, sb, r, s;
        logic car, of;
        ua = int'(a); ub = int'(b);
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        car = 1'b0; of = 1'b0; r = 0;
        case (op)
            3'd0: begin r = ua + ub; car = (r >= FULL); s = sa + sb; of = (s > HALF - 1) || (s < -HALF); end
            3'd1: begin r = ua - ub; car = (ua < ub);   s = sa - sb; of = (s > HALF - 1) || (s < -HALF); end
            3'd2: r = FULL - 1 - ua;
            3'd3: r = ua & ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: r = (sa < sb) ? 1 : 0;
            3'd7: r = (ua == ub) ? 1 : 0;
            default: r = 0;
        endcase
        r = ((r % FULL) + FULL) % FULL;
        return {car, of, OPW'(r)};
    endfunction

    // External ALU; noise corrupts it outside DRIVE so any off-cycle sampling shows up.
    always_comb {alu_car, alu_of, alu_res} = alu_model(alu_a, alu_b, alu_ctrl) ^ alu_noise;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, ".rsp_res"},   32'(rsp_res),   32'd0);
        check_eq({tag, ".rsp_flags"}, 32'({rsp_car, rsp_of, rsp_zero}), 32'd0);
        check_eq({tag, ".alu_a"},     32'(alu_a),     32'd0);
        check_eq({tag, ".alu_b"},     32'(alu_b),     32'd0);
        check_eq({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'd0);
        check_eq({tag, ".op_count"},  32'(op_count),  32'd0);
    endtask

    // One full transaction: accept, DRIVE, RESP held for 'hold' cycles, then handshake.
    task automatic do_cmd(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic [2:0] op,
                          input logic chain, input int hold);
        logic [OPW-1:0] ea;
        logic [OPW+1:0] ev;
        int w;
        ea = (CHAIN_EN && chain) ? last_res : a;
        ev = alu_model(ea, b, op);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check_eq("wait_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
`ifdef ALU_CMD_ISSUER_CHAIN_EN
        cmd_chain = chain;
`endif
        rsp_ready = (hold == 0);
        tick();
        alu_noise = '0;
        cmd_valid = 1'($urandom); cmd_a = OPW'($urandom); cmd_b = OPW'($urandom); cmd_op = 3'($urandom);
        check_eq("drive.cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("drive.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("drive.alu_a",     32'(alu_a),     32'(ea));
        check_eq("drive.alu_b",     32'(alu_b),     32'(b));
        check_eq("drive.alu_ctrl",  32'(alu_ctrl),  32'(op));
        tick();
        alu_noise = OPW'($urandom_range(1, FULL - 1));
        check_eq("resp.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("resp.rsp_res",   32'(rsp_res),   32'(ev[OPW-1:0]));
        check_eq("resp.flags",     32'({rsp_car, rsp_of}), 32'(ev[OPW+1:OPW]));
        check_eq("resp.zero",      32'(rsp_zero),  32'(ev[OPW-1:0] == '0));
        check_eq("resp.alu_a",     32'(alu_a),     32'(ea));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'($urandom); cmd_a = OPW'($urandom); cmd_op = 3'($urandom);
            tick();
            check_eq("hold.rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold.cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("hold.payload",   32'({rsp_car, rsp_of, rsp_zero, rsp_res}),
                     32'({ev[OPW+1:OPW], ev[OPW-1:0] == '0, ev[OPW-1:0]}));
            check_eq("hold.op_count",  32'(op_count), 32'(exp_cnt));
        end
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CNTW);
        last_res = ev[OPW-1:0];
        check_eq("done.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("done.cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("done.op_count",  32'(op_count),  32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; alu_noise = '0; last_res = '0;
`ifdef ALU_CMD_ISSUER_CHAIN_EN
        cmd_chain = 1'b0;
`endif
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Reset while in DRIVE abandons the command.
        cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd6; cmd_op = 3'd1;
        tick();
        check_eq("abort.alu_a", 32'(alu_a), 32'd9);
        rst = 1'b1; cmd_valid = 1'b0;
        tick();
        check_reset_vals("abort_drive");
        rst = 1'b0;
        tick();
        check_eq("abort.no_rsp", 32'(rsp_valid), 32'd0);

        do_cmd(4'd3, 4'd4, 3'd0, 1'b0, 0);
        do_cmd(4'd7, 4'd1, 3'd0, 1'b0, 0);
        do_cmd(4'd5, 4'd5, 3'd1, 1'b0, 0);
        do_cmd(4'd2, 4'd9, 3'd6, 1'b0, 5);

        // Reset beats a simultaneous response handshake.
        cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = 3'd0; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check_eq("abort_resp.rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1; rst = 1'b1;
        tick();
        check_reset_vals("abort_resp");
        rst = 1'b0; exp_cnt = 0; last_res = '0;

`ifdef ALU_CMD_ISSUER_CHAIN_EN
        do_cmd(4'd2, 4'd3, 3'd0, 1'b0, 0);
        do_cmd(4'd0, 4'd1, 3'd0, 1'b1, 0);
        check_eq("chain.rsp_res", 32'(rsp_res), 32'd6);
`endif

        for (int i = 0; i < 40; i++)
            do_cmd(OPW'($urandom), OPW'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 3));

        // Back-to-back run from a fresh reset: counter wraps and throughput is 3 cycles/command.
        rst = 1'b1;
        tick();
        rst = 1'b0; exp_cnt = 0; last_res = '0;
        c0 = cyc;
        for (int i = 0; i < 256; i++)
            do_cmd(OPW'($urandom), OPW'($urandom), 3'($urandom), 1'($urandom), 0);
        check_eq("wrap.op_count", 32'(op_count), 32'd0);
        check_eq("wrap.cycles",   32'(cyc - c0), 32'd768);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
